// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM-subset control unit.
package arm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] CLASS_DP = 2'b00;
    localparam logic [1:0] CLASS_LS = 2'b01;
    localparam logic [1:0] CLASS_BR = 2'b10;

    typedef struct packed {
        logic undef;
        logic branch;
        logic ls;
        logic load;
        logic no_wb;
        logic set_flags;
        logic arith;
    } dec_t;

    // Decode from instr[31:20]: cond, class, I bit, opcode, S/L bit.
    function automatic dec_t decode(input logic [11:0] hi);
        dec_t       d;
        logic [3:0] op;
        logic       cmp;
        logic       op_ok;
        d     = '0;
        op    = hi[4:1];
        cmp   = (op == OP_CMP) || (op == OP_TST) || (op == OP_TEQ);
        op_ok = op inside {OP_ADD, OP_SUB, OP_CMP, OP_TST, OP_TEQ,
                           OP_BIC, OP_ORR, OP_EOR, OP_MOV, OP_MVN};
        case (hi[7:6])
            CLASS_DP: begin
                d.undef     = !op_ok;
                d.no_wb     = cmp;
                d.set_flags = hi[0] || cmp;
                d.arith     = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
            end
            CLASS_LS: begin
                d.ls   = 1'b1;
                d.load = hi[0];
            end
            CLASS_BR: begin
                d.branch = hi[5];
                d.undef  = !hi[5];
            end
            default: d.undef = 1'b1;
        endcase
        if (hi[11:8] == COND_NV) d.undef = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against {N,Z,C,V}.
import arm_ctrl_pkg::*;

module cond_eval (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = nzcv[3];
        z    = nzcv[2];
        c    = nzcv[1];
        v    = nzcv[0];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_ctrl_fsm.sv
// Multi-cycle control unit: decode, EXEC/MEM/WB sequencing, NZCV flag register.
import arm_ctrl_pkg::*;

module arm_ctrl_fsm #(
    parameter int unsigned width = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              mem_done,
    output logic [3:0]        alu_op,
    output logic              ldr,
    output logic              str,
    output logic              oprd2_imm,
    output logic [width-1:0]  imm_ext,
    output logic [3:0]        rn_addr,
    output logic [3:0]        rd_addr,
    output logic [3:0]        rm_addr,
    output logic              reg_we,
    output logic              branch_taken,
    output logic [23:0]       branch_offset,
    output logic              undef,
    output logic [3:0]        nzcv
);

    state_t      state;
    logic [24:0] ir_q;
    dec_t        dec_q;
    logic        pass_q;
    dec_t        dec_c;
    logic        pass_c;

    // The flags cannot change between accept and the end of EXEC, so the
    // condition is resolved at accept and carried through EXEC.
    cond_eval u_cond_eval (
        .cond (instr[31:28]),
        .nzcv (nzcv),
        .pass (pass_c)
    );

    assign dec_c = decode(instr[31:20]);

    assign oprd2_imm     = ir_q[24];
    assign branch_offset = ir_q[23:0];
    assign rn_addr       = ir_q[19:16];
    assign rd_addr       = ir_q[15:12];
    assign rm_addr       = ir_q[3:0];
    assign imm_ext       = width'(ir_q[11:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ir_q         <= '0;
            dec_q        <= '0;
            pass_q       <= 1'b0;
            instr_ready  <= 1'b0;
            alu_op       <= '0;
            ldr          <= 1'b0;
            str          <= 1'b0;
            reg_we       <= 1'b0;
            branch_taken <= 1'b0;
            undef        <= 1'b0;
            nzcv         <= '0;
        end else begin
            branch_taken <= 1'b0;
            undef        <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_ready && instr_valid) begin
                        state       <= EXEC;
                        instr_ready <= 1'b0;
                        ir_q        <= {instr[25], instr[23:0]};
                        dec_q       <= dec_c;
                        pass_q      <= pass_c;
                        alu_op      <= instr[24:21];
                        if (dec_c.undef) begin
                            undef <= 1'b1;
                        end else if (pass_c) begin
                            branch_taken <= dec_c.branch;
                            ldr          <= dec_c.ls && dec_c.load;
                            str          <= dec_c.ls && !dec_c.load;
                        end
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    alu_op <= '0;
                    if (dec_q.undef || !pass_q || dec_q.branch || dec_q.no_wb) begin
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                    end else if (dec_q.ls) begin
                        state <= MEM;
                    end else begin
                        state  <= WB;
                        reg_we <= 1'b1;
                    end
                    // Logical ops keep C and V.
                    if (!dec_q.undef && pass_q && dec_q.set_flags) begin
                        if (dec_q.arith)
                            nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                        else
                            nzcv <= {alu_negative, alu_zero, nzcv[1:0]};
                    end
                end
                MEM: begin
                    if (mem_done) begin
                        ldr <= 1'b0;
                        str <= 1'b0;
                        if (dec_q.load) begin
                            state  <= WB;
                            reg_we <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            instr_ready <= 1'b1;
                        end
                    end
                end
                WB: begin
                    reg_we      <= 1'b0;
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_ctrl_fsm.sv
// Scoreboard bench for arm_ctrl_fsm: directed instructions, event queue checked by a monitor.
module tb_arm_ctrl_fsm;

    localparam logic [1:0] EV_WB    = 2'd0;
    localparam logic [1:0] EV_BR    = 2'd1;
    localparam logic [1:0] EV_UNDEF = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] data;
        logic [3:0]  flags;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        alu_negative, alu_zero, alu_carry, alu_overflow;
    logic        mem_done;
    logic [3:0]  alu_op;
    logic        ldr, str, oprd2_imm;
    logic [31:0] imm_ext;
    logic [3:0]  rn_addr, rd_addr, rm_addr;
    logic        reg_we, branch_taken, undef;
    logic [23:0] branch_offset;
    logic [3:0]  nzcv;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t got_ev;
    exp_t exp_ev;

    arm_ctrl_fsm #(.width(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .mem_done      (mem_done),
        .alu_op        (alu_op),
        .ldr           (ldr),
        .str           (str),
        .oprd2_imm     (oprd2_imm),
        .imm_ext       (imm_ext),
        .rn_addr       (rn_addr),
        .rd_addr       (rd_addr),
        .rm_addr       (rm_addr),
        .reg_we        (reg_we),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .undef         (undef),
        .nzcv          (nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want done");
        $fatal(1);
    end

    // Monitor: every output event must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && (reg_we || branch_taken || undef)) begin
            got_ev.kind  = reg_we ? EV_WB : (branch_taken ? EV_BR : EV_UNDEF);
            got_ev.data  = reg_we ? 24'(rd_addr) : (branch_taken ? branch_offset : 24'd0);
            got_ev.flags = nzcv;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got kind=%0d data=%h nzcv=%b, want none",
                         got_ev.kind, got_ev.data, got_ev.flags);
            end else begin
                exp_ev = sb.pop_front();
                if (got_ev !== exp_ev) begin
                    miscompares++;
                    $display("FAIL event: got kind=%0d data=%h nzcv=%b, want kind=%0d data=%h nzcv=%b",
                             got_ev.kind, got_ev.data, got_ev.flags,
                             exp_ev.kind, exp_ev.data, exp_ev.flags);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        {alu_negative, alu_zero, alu_carry, alu_overflow} = f;
    endtask

    task automatic push(input logic [1:0] k, input logic [23:0] d, input logic [3:0] f);
        exp_t e;
        e.kind  = k;
        e.data  = d;
        e.flags = f;
        sb.push_back(e);
    endtask

    // Offer an instruction; returns just after the accept edge (cycle 1 = EXEC).
    task automatic issue(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(instr_ready), 32'd1);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        mem_done    = 1'b0;
        set_flags(4'b0000);
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_nzcv",  32'(nzcv), 32'd0);
        chk("rst_outs",  32'({alu_op, ldr, str, reg_we, branch_taken, undef}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_rst", 32'(instr_ready), 32'd1);

        // ADDS r0, r1, r2 with N=1 C=1
        set_flags(4'b1010);
        push(EV_WB, 24'd0, 4'b1010);
        issue(32'hE0910002);
        @(negedge clk);
        chk("adds_alu_op", 32'(alu_op), 32'h4);
        chk("adds_rn", 32'(rn_addr), 32'd1);
        chk("adds_rm", 32'(rm_addr), 32'd2);
        @(negedge clk);
        chk("adds_alu_op_wb", 32'(alu_op), 32'd0);
        @(negedge clk);
        chk("adds_ready_c3", 32'(instr_ready), 32'd1);

        // CMP r1, r2 with Z=1, then BEQ
        set_flags(4'b0100);
        issue(32'hE1510002);
        @(negedge clk);
        chk("cmp_alu_op", 32'(alu_op), 32'hA);
        @(negedge clk);
        chk("cmp_nzcv", 32'(nzcv), 32'h4);
        chk("cmp_ready_c2", 32'(instr_ready), 32'd1);
        set_flags(4'b0000);
        push(EV_BR, 24'h000004, 4'b0100);
        issue(32'h0A000004);
        @(negedge clk);
        @(negedge clk);
        chk("beq_pulse_end", 32'(branch_taken), 32'd0);
        chk("beq_ready_c2", 32'(instr_ready), 32'd1);

        // MOVNE and BNE with Z=1: both skipped
        set_flags(4'b1111);
        issue(32'h11A00001);
        @(negedge clk);
        @(negedge clk);
        chk("movne_ready_c2", 32'(instr_ready), 32'd1);
        chk("movne_nzcv", 32'(nzcv), 32'h4);
        issue(32'h1A000004);
        @(negedge clk);
        @(negedge clk);
        chk("bne_ready_c2", 32'(instr_ready), 32'd1);

        // LDR r0, [r1] with mem_done on the third MEM cycle
        set_flags(4'b0000);
        push(EV_WB, 24'd0, 4'b0100);
        issue(32'hE5910000);
        @(negedge clk);
        chk("ldr_alu_op", 32'(alu_op), 32'hC);
        chk("ldr_c1", 32'(ldr), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("ldr_wait", 32'(ldr), 32'd1);
        end
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("ldr_drop_wb", 32'(ldr), 32'd0);
        @(negedge clk);
        chk("ldr_ready", 32'(instr_ready), 32'd1);

        // STR with mem_done already high: completes on the first MEM cycle
        mem_done = 1'b1;
        issue(32'hE5810000);
        @(negedge clk);
        chk("str_c1", 32'(str), 32'd1);
        @(negedge clk);
        chk("str_mem", 32'(str), 32'd1);
        @(negedge clk);
        mem_done = 1'b0;
        chk("str_done", 32'(str), 32'd0);
        chk("str_ready", 32'(instr_ready), 32'd1);

        // SUBS then EORS: logical op keeps C and V
        set_flags(4'b0011);
        push(EV_WB, 24'd0, 4'b0011);
        issue(32'hE0510002);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        set_flags(4'b1000);
        push(EV_WB, 24'd0, 4'b1011);
        issue(32'hE0310002);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("eors_nzcv", 32'(nzcv), 32'hB);

        // Reset during a MEM wait
        issue(32'hE5910000);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_ldr", 32'(ldr), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", 32'({alu_op, ldr, str, reg_we, instr_ready}), 32'd0);
        chk("rst_mid_nzcv", 32'(nzcv), 32'd0);
        chk("rst_mid_rd", 32'(rd_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("rst_mid_ready", 32'(instr_ready), 32'd1);

        // Undefined: AND opcode and cond 1111
        set_flags(4'b1111);
        push(EV_UNDEF, 24'd0, 4'b0000);
        issue(32'hE0000000);
        @(negedge clk);
        @(negedge clk);
        chk("and_ready_c2", 32'(instr_ready), 32'd1);
        chk("and_nzcv", 32'(nzcv), 32'd0);
        push(EV_UNDEF, 24'd0, 4'b0000);
        issue(32'hF1A00001);
        @(negedge clk);
        @(negedge clk);
        chk("nv_ready_c2", 32'(instr_ready), 32'd1);
        chk("nv_nzcv", 32'(nzcv), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arm_ctrl_fsm.md
# arm_ctrl_fsm

Multi-cycle control unit that drives the ALU of the ARM-subset datapath. It accepts one 32-bit instruction at a time and decodes it into ALU opcode, register addresses, and load/store strobes. It sequences execute, memory and writeback, holds the architectural NZCV flag register fed from the ALU status outputs, and evaluates ARM condition codes.

## Interface
Parameters:
- `width`, 32, datapath width; used only for the `imm12` zero-extension on `imm_ext`.

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `instr_valid`  in  1  instruction offered
- `instr`  in  32  instruction word
- `instr_ready`  out  1  unit in IDLE, accepts instruction
- `alu_negative`, `alu_zero`, `alu_carry`, `alu_overflow`  in  1 each  ALU status
- `mem_done`  in  1  data memory access complete
- `alu_op`  out  4  ALU opcode, instr[24:21]
- `ldr`, `str`  out  1 each  memory strobes to ALU and data memory
- `oprd2_imm`  out  1  operand 2 from `imm_ext` (instr[25])
- `imm_ext`  out  width  zero-extended instr[11:0]
- `rn_addr`, `rd_addr`, `rm_addr`  out  4 each  instr[19:16], [15:12], [3:0]
- `reg_we`  out  1  register-file write strobe, one cycle
- `branch_taken`  out  1  one-cycle pulse
- `branch_offset`  out  24  instr[23:0]
- `undef`  out  1  one-cycle pulse for an unsupported encoding
- `nzcv`  out  4  flag register {N,Z,C,V}

## Operation
- Instruction class from instr[27:26]: 00 data-processing, 01 load/store (instr[20]=1 LDR, 0 STR), 10 with instr[25]=1 branch. Anything else is undefined.
- Supported DP opcodes: 0100 ADD, 0010 SUB, 1010 CMP, 1000 TST, 1001 TEQ, 1110 BIC, 1100 ORR, 0001 EOR, 1101 MOV, 1111 MVN. All other opcodes are undefined.
- Condition instr[31:28]: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1. 1111 is undefined.
- The condition is evaluated in EXEC against the registered `nzcv`.
- FSM states and transitions:
  - IDLE: `instr_ready`=1. Handshake `instr_valid & instr_ready` latches `instr` and moves to EXEC.
  - EXEC: decoded outputs are driven.
    - Undefined encoding: pulse `undef`, go to IDLE.
    - Condition false: no strobes, no flag update, go to IDLE.
    - Branch: pulse `branch_taken`, go to IDLE.
    - DP: go to WB. CMP, TST and TEQ go to IDLE instead, with no writeback.
    - LDR/STR: assert `ldr`/`str`, go to MEM.
  - MEM: `ldr`/`str` held. On `mem_done`, LDR goes to WB and STR goes to IDLE. `mem_done` is checked from the first MEM cycle.
  - WB: `reg_we`=1 with `rd_addr` valid, then go to IDLE.
- Flag update happens on the edge leaving EXEC, when instr[20]=1 or the opcode is CMP/TST/TEQ, and only if the condition passed.
  - ADD, SUB, CMP load all four flags.
  - Logical ops load N and Z only; C and V are preserved.
- `alu_op` is forced to 0000 in every state except EXEC.
- `mem_done` outside MEM is ignored.
- `instr_valid` is ignored outside IDLE.

## Timing
- Reset (asynchronous): state=IDLE, latched instruction=0, `nzcv`=0000, and every output 0, including `instr_ready`. `instr_ready`=1 from the first cycle after release.
- Reset asserted mid-operation abandons the instruction: no `reg_we`, no flag commit.
- Latency from the accept edge (cycle 0):
  - EXEC at cycle 1.
  - DP writeback at cycle 2; next accept at cycle 3.
  - Compare, branch, condition-fail and undefined: next accept at cycle 2.
  - LDR: `reg_we` one cycle after the `mem_done` cycle.
- `nzcv` is visible one cycle after EXEC, so a back-to-back conditional instruction sees the new flags.

## Structure
- Shared package `arm_ctrl_pkg` holds:
  - state enum (IDLE, EXEC, MEM, WB)
  - opcode constants
  - condition-code constants
  - instruction-class constants
- Sub-module `cond_eval` is combinational: in `cond[3:0]`, `nzcv[3:0]`; out `pass`.

## Test plan
- ADDS `0xE0910002`, ALU flags N=1 Z=0 C=1 V=0 -> cycle 1: `alu_op`=0100, `rn_addr`=1, `rm_addr`=2. Cycle 2: `reg_we`=1, `rd_addr`=0, `nzcv`=1010. `instr_ready`=1 at cycle 3.
- CMP `0xE1510002` with `alu_zero`=1, then BEQ `0x0A000004` -> `nzcv`=0100, no `reg_we` for CMP. Then `branch_taken` pulse with `branch_offset`=0x000004.
- `nzcv`=0100, MOVNE `0x11A00001` -> no `reg_we`, `nzcv` unchanged, `instr_ready` back at cycle 2.
- LDR `0xE5910000`, `mem_done` on the 3rd MEM cycle -> `ldr` high for the whole wait, then `reg_we` next cycle with `rd_addr`=0. STR `0xE5810000` -> `str` high, no `reg_we`.
- Reset asserted during a MEM wait -> all outputs 0 immediately, `nzcv`=0000, no `reg_we`. `instr_ready`=1 on the first cycle after release.
- AND `0xE0000000` and cond 1111 `0xF1A00001` -> each gives an `undef` pulse at cycle 1, no `reg_we`, no flag change.
